// File: rtl/minv_mdiv_seq.sv
// Host-side sequencer for the modular inverse/division core: loads p/a/b word streams,
// starts the core, waits for ready and streams the selected result out. Optional watchdog: MINV_SEQ_TIMEOUT_EN.
module minv_mdiv_seq #(
  parameter int unsigned WORDS          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic        op_mode,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        err,
  output logic [15:0] core_datain,
  output logic        core_loada,
  output logic        core_loadb,
  output logic        core_loadp,
  output logic        core_minv_mdiv,
  output logic        core_en,
  output logic        core_outx1,
  output logic        core_outx2,
  input  logic [15:0] core_regx1out,
  input  logic [15:0] core_regx2out,
  input  logic        core_rdy,
  input  logic        core_flag
);

  localparam int unsigned CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_P, S_LOAD_A, S_LOAD_B, S_START, S_WAIT, S_READ
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          mode_q;
  logic          flag_q;
  logic [1:0]    guard_q;
  logic          loading;
  logic          rdy_ok;

  assign loading = (state_q == S_LOAD_P) || (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  // Ready from the previous operation may still be high for the first WAIT cycles.
  assign rdy_ok  = (guard_q == 2'd2) && core_rdy;

`ifdef MINV_SEQ_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_q;
  logic        err_q;
  assign err = err_q;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b1;
      flag_q  <= 1'b0;
      guard_q <= '0;
`ifdef MINV_SEQ_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (op_valid) begin
            mode_q  <= op_mode;
            cnt_q   <= '0;
            state_q <= S_LOAD_P;
`ifdef MINV_SEQ_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
          end
        end
        S_LOAD_P, S_LOAD_A, S_LOAD_B: begin
          if (in_valid) begin
            if (cnt_q == LAST) begin
              cnt_q <= '0;
              case (state_q)
                S_LOAD_P: state_q <= S_LOAD_A;
                S_LOAD_A: state_q <= mode_q ? S_START : S_LOAD_B;
                default:  state_q <= S_START;
              endcase
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_START: begin
          guard_q <= '0;
`ifdef MINV_SEQ_TIMEOUT_EN
          tmo_q   <= '0;
`endif
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (rdy_ok) begin
            flag_q  <= core_flag;
            state_q <= S_READ;
          end else begin
            if (guard_q != 2'd2) guard_q <= guard_q + 2'd1;
`ifdef MINV_SEQ_TIMEOUT_EN
            if (tmo_q == TMO_LAST) begin
              err_q   <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              tmo_q <= tmo_q + 16'd1;
            end
`endif
          end
        end
        S_READ: begin
          if (out_ready) begin
            if (cnt_q == LAST) begin
              cnt_q   <= '0;
              state_q <= S_IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign op_ready       = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign in_ready       = loading;
  assign core_datain    = loading ? in_data : '0;
  assign core_loadp     = (state_q == S_LOAD_P) && in_valid;
  assign core_loada     = (state_q == S_LOAD_A) && in_valid;
  assign core_loadb     = (state_q == S_LOAD_B) && in_valid;
  assign core_minv_mdiv = mode_q;
  assign core_en        = (state_q == S_START);
  assign out_valid      = (state_q == S_READ);
  assign out_data       = out_valid ? (flag_q ? core_regx2out : core_regx1out) : '0;
  assign out_last       = out_valid && (cnt_q == LAST);
  assign core_outx1     = out_valid && out_ready && !flag_q;
  assign core_outx2     = out_valid && out_ready && flag_q;

endmodule

// File: tb/tb_minv_mdiv_seq.sv
// Randomized bench for minv_mdiv_seq with a behavioural core stand-in and an arithmetic reference model.
module tb_minv_mdiv_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0, op_ready, op_mode = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid, out_ready = 1'b0, out_last, busy, err;
  logic [15:0] out_data, core_datain;
  logic        core_loada, core_loadb, core_loadp, core_minv_mdiv, core_en, core_outx1, core_outx2;
  logic [15:0] core_regx1out, core_regx2out;
  logic        core_rdy = 1'b0, core_flag = 1'b0;

  always #5 clk = ~clk;

  minv_mdiv_seq #(.WORDS(16), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready), .op_mode(op_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .err(err),
    .core_datain(core_datain), .core_loada(core_loada), .core_loadb(core_loadb), .core_loadp(core_loadp),
    .core_minv_mdiv(core_minv_mdiv), .core_en(core_en), .core_outx1(core_outx1), .core_outx2(core_outx2),
    .core_regx1out(core_regx1out), .core_regx2out(core_regx2out), .core_rdy(core_rdy), .core_flag(core_flag)
  );

  int unsigned n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- core stand-in (extended Euclid on word 0) ----------------
  int unsigned cfg_lat = 3;
  bit          cfg_flag = 1'b0, cfg_ovr = 1'b0, cfg_hang = 1'b0;
  logic [255:0] cp = '0, ca = '0, cb = '0, x1 = '0, x2 = '0;
  bit          pend = 1'b0;
  int unsigned lat = 0, dcnt = 0;

  assign core_regx1out = x1[15:0];
  assign core_regx2out = x2[15:0];

  function automatic longint inv_euclid(input longint a, input longint m);
    longint t = 0, nt = 1, r = m, nr = a, q, tmp;
    while (nr != 0) begin
      q = r / nr;
      tmp = t - q * nt; t = nt; nt = tmp;
      tmp = r - q * nr; r = nr; nr = tmp;
    end
    if (t < 0) t += m;
    return t;
  endfunction

  always @(posedge clk) begin
    logic [255:0] res;
    longint       pv, av, bv, iv;
    if (core_loadp) cp <= {core_datain, cp[255:16]};
    if (core_loada) ca <= {core_datain, ca[255:16]};
    if (core_loadb) cb <= {core_datain, cb[255:16]};
    if (core_outx1) x1 <= x1 >> 16;
    if (core_outx2) x2 <= x2 >> 16;
    if (core_en) begin
      pend <= !cfg_hang;
      lat  <= cfg_lat;
      dcnt <= 2;
    end else begin
      if (dcnt != 0) begin
        dcnt <= dcnt - 1;
        if (dcnt == 1) core_rdy <= 1'b0;
      end
      if (pend) begin
        if (lat == 0) begin
          pv = longint'(cp[15:0]); av = longint'(ca[15:0]); bv = longint'(cb[15:0]);
          iv = inv_euclid(av % pv, pv);
          res = cp ^ ca ^ (core_minv_mdiv ? 256'd0 : cb);
          res[15:0] = 16'(core_minv_mdiv ? iv : (bv * iv) % pv);
          if (cfg_ovr) begin
            x2 <= 256'h1234; x1 <= '1; core_flag <= 1'b1;
          end else if (cfg_flag) begin
            x2 <= res; x1 <= ~res; core_flag <= 1'b1;
          end else begin
            x1 <= res; x2 <= ~res; core_flag <= 1'b0;
          end
          core_rdy <= 1'b1;
          pend     <= 1'b0;
        end else begin
          lat <= lat - 1;
        end
      end
    end
  end

  // ---------------- monitor: records per-operation activity ----------------
  logic [15:0] q_out[$];
  int unsigned np, na, nb, ne, nx1, nx2, n_ovl, n_unst, n_last, last_idx, n_ov;
  logic        mode_at_en;
  bit          stalled_prev = 1'b0;
  logic [15:0] prev_data = '0;

  always @(negedge clk) begin
    if (op_valid && op_ready) begin
      q_out.delete();
      np = 0; na = 0; nb = 0; ne = 0; nx1 = 0; nx2 = 0;
      n_ovl = 0; n_unst = 0; n_last = 0; last_idx = 99; n_ov = 0;
      mode_at_en = 1'bx;
    end else begin
      if (core_loadp) np++;
      if (core_loada) na++;
      if (core_loadb) nb++;
      if (core_en) begin ne++; mode_at_en = core_minv_mdiv; end
      if (core_outx1) nx1++;
      if (core_outx2) nx2++;
      if (32'(core_loadp) + 32'(core_loada) + 32'(core_loadb) + 32'(core_en) + 32'(core_outx1) + 32'(core_outx2) > 1)
        n_ovl++;
      if (out_valid) n_ov++;
      if (stalled_prev && out_valid && out_data !== prev_data) n_unst++;
      if (out_valid && !out_ready && (core_outx1 || core_outx2)) n_unst++;
      if (out_valid && out_ready) begin
        q_out.push_back(out_data);
        if (out_last) begin n_last++; last_idx = q_out.size() - 1; end
      end
    end
    stalled_prev = out_valid && !out_ready;
    prev_data    = out_data;
  end

  // ---------------- reference model (Fermat inverse) and driver ----------------
  logic [15:0] pw[16], aw[16], bw[16], ew[16];
  bit          exp_flag;

  function automatic longint powmod(input longint b, input longint e, input longint m);
    longint r = 1;
    b = b % m;
    while (e > 0) begin
      if (e[0]) r = (r * b) % m;
      b = (b * b) % m;
      e = e >> 1;
    end
    return r;
  endfunction

  task automatic build_expect(input bit mode, input bit ovr);
    longint p0, iv;
    p0 = longint'(pw[0]);
    iv = powmod(longint'(aw[0]), p0 - 2, p0);
    for (int k = 0; k < 16; k++) begin
      if (ovr) ew[k] = (k == 0) ? 16'h1234 : 16'h0000;
      else if (k == 0) ew[k] = 16'(mode ? iv : (longint'(bw[0]) * iv) % p0);
      else ew[k] = pw[k] ^ aw[k] ^ (mode ? 16'h0 : bw[k]);
    end
    exp_flag = ovr ? 1'b1 : cfg_flag;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // kind: 0 = normal, 1 = reset at beat 7 of LOAD_A, 2 = core hangs (watchdog)
  task automatic run_op(input bit mode, input bit stall_in, input bit bp, input int kind);
    int unsigned cyc;
    cyc = 0;
    while (!op_ready && cyc < 200) begin tick(); cyc++; end
    chk("op_ready_before_cmd", op_ready, 1'b1);
    op_mode = mode; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    chk("err_clear_on_cmd", err, 1'b0);
    for (int s = 0; s < (mode ? 2 : 3); s++) begin
      for (int k = 0; k < 16; k++) begin
        if (stall_in && s == 1 && k == 7) begin
          in_valid = 1'b0;
          repeat (5) tick();
        end
        if (kind == 1 && s == 1 && k == 7) begin
          rst = 1'b1;
          #2;
          chk("rst_strobes", {core_loadp, core_loada, core_loadb, core_en, core_outx1, core_outx2}, 6'b0);
          chk("rst_op_ready", op_ready, 1'b1);
          chk("rst_busy", busy, 1'b0);
          chk("rst_in_ready", in_ready, 1'b0);
          in_valid = 1'b0;
          #1 rst = 1'b0;
          tick();
          return;
        end
        in_valid = 1'b1;
        in_data  = (s == 0) ? pw[k] : (s == 1) ? aw[k] : bw[k];
        tick();
      end
    end
    in_valid = 1'b0; in_data = '0;
    if (kind == 2) begin
      cyc = 0;
      while (!err && cyc < 400) begin tick(); cyc++; end
      chk("tmo_err_set", err, 1'b1);
      chk("tmo_latency_ok", (cyc >= 95 && cyc <= 110), 1'b1);
      chk("tmo_idle", op_ready, 1'b1);
      chk("tmo_no_out_valid", n_ov, 0);
      chk("tmo_single_en", ne, 1);
      return;
    end
    cyc = 0;
    while (q_out.size() < 16 && cyc < 3000) begin
      out_ready = bp ? cyc[0] : 1'b1;
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    tick();
    chk("out_in_time", (cyc < 3000), 1'b1);
    chk("out_words", q_out.size(), 16);
    for (int k = 0; k < 16; k++)
      if (k < q_out.size()) chk($sformatf("word%0d", k), q_out[k], ew[k]);
    chk("last_count", n_last, 1);
    chk("last_pos", last_idx, 15);
    chk("loadp_beats", np, 16);
    chk("loada_beats", na, 16);
    chk("loadb_beats", nb, mode ? 0 : 16);
    chk("en_pulses", ne, 1);
    chk("mode_at_en", mode_at_en, mode);
    chk("outx_sel", exp_flag ? nx2 : nx1, 16);
    chk("outx_other", exp_flag ? nx1 : nx2, 0);
    chk("strobe_overlap", n_ovl, 0);
    chk("stall_stable", n_unst, 0);
    chk("idle_after", {busy, op_ready}, 2'b01);
    chk("err_low", err, 1'b0);
  endtask

  task automatic set_small(input logic [15:0] p, input logic [15:0] a, input logic [15:0] b);
    for (int k = 0; k < 16; k++) begin pw[k] = '0; aw[k] = '0; bw[k] = '0; end
    pw[0] = p; aw[0] = a; bw[0] = b;
  endtask

  int unsigned primes[6] = '{11, 13, 251, 257, 7919, 65521};

  initial begin
    bit m, si, bpr;
    int unsigned pr;
    repeat (2) tick();
    chk("reset_op_ready", op_ready, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_in_ready", in_ready, 1'b0);
    chk("reset_strobes", {core_loadp, core_loada, core_loadb, core_en, core_outx1, core_outx2}, 6'b0);
    chk("reset_err", err, 1'b0);
    #2 rst = 1'b0;
    tick();

    set_small(16'd11, 16'd3, 16'd5);
    cfg_flag = 1'b0; cfg_lat = 4;
    build_expect(1'b1, 1'b0); run_op(1'b1, 1'b0, 1'b0, 0);
    build_expect(1'b0, 1'b0); run_op(1'b0, 1'b0, 1'b0, 0);
    build_expect(1'b1, 1'b0); run_op(1'b1, 1'b1, 1'b1, 0);
    cfg_ovr = 1'b1;
    build_expect(1'b1, 1'b1); run_op(1'b1, 1'b0, 1'b0, 0);
    cfg_ovr = 1'b0;
    run_op(1'b1, 1'b0, 1'b0, 1);
    build_expect(1'b1, 1'b0); run_op(1'b1, 1'b0, 1'b0, 0);

    for (int n = 0; n < 10; n++) begin
      pr = primes[$urandom_range(5, 0)];
      m = 1'($urandom); si = 1'($urandom); bpr = 1'($urandom);
      cfg_flag = 1'($urandom);
      cfg_lat  = $urandom_range(12, 3);
      for (int k = 0; k < 16; k++) begin
        pw[k] = 16'($urandom); aw[k] = 16'($urandom); bw[k] = 16'($urandom);
      end
      pw[0] = 16'(pr);
      aw[0] = 16'($urandom_range(pr - 1, 1));
      build_expect(m, 1'b0);
      run_op(m, si, bpr, 0);
    end

`ifdef MINV_SEQ_TIMEOUT_EN
    cfg_hang = 1'b1;
    set_small(16'd11, 16'd3, 16'd5);
    run_op(1'b1, 1'b0, 1'b0, 2);
    cfg_hang = 1'b0; cfg_flag = 1'b0; cfg_lat = 5;
    build_expect(1'b1, 1'b0); run_op(1'b1, 1'b0, 1'b0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "simulation time limit");
  end
endmodule
